// File: rtl/light_scheduler.sv
// Mode/alarm controller for the hours/minutes RTC, with minute prescaler and LED ramp.
// Latency: the o_inc_* pulses and o_light_on are registered, so they appear one cycle after their cause. o_brightness moves one step per cycle.
// Backpressure: none. Button pulses are consumed in the cycle they arrive.
//
// Ports:
//   i_clk_1hz / i_rst          1 Hz timebase, asynchronous active-high reset
//   i_btn_mode / i_btn_inc     debounced one-cycle button pulses
//   i_hours / i_minutes        current RTC time
//   o_inc_hours / o_inc_minutes  registered RTC increment pulses (never both high)
//   o_mode                     FSM state (RUN=0 .. SET_OFF_M=6)
//   o_disp_h / o_disp_m        time shown for the current mode
//   o_light_on / o_brightness  ON-window flag and ramped LED level
module light_scheduler #(
    parameter int SEC_PER_MIN  = 60,
    parameter int RAMP_STEP    = 8,
    parameter int IDLE_TIMEOUT = 30,
    parameter int DEF_ON_H     = 18,
    parameter int DEF_ON_M     = 0,
    parameter int DEF_OFF_H    = 23,
    parameter int DEF_OFF_M    = 0
) (
    input  logic       i_clk_1hz,
    input  logic       i_rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic [5:0] i_hours,
    input  logic [5:0] i_minutes,
    output logic       o_inc_hours,
    output logic       o_inc_minutes,
    output logic [2:0] o_mode,
    output logic [5:0] o_disp_h,
    output logic [5:0] o_disp_m,
    output logic       o_light_on,
    output logic [7:0] o_brightness
);

    localparam int SEC_W  = (SEC_PER_MIN  > 2) ? $clog2(SEC_PER_MIN)  : 1;
    localparam int IDLE_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_PER_MIN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_CLK_H = 3'd1,
        SET_CLK_M = 3'd2,
        SET_ON_H  = 3'd3,
        SET_ON_M  = 3'd4,
        SET_OFF_H = 3'd5,
        SET_OFF_M = 3'd6
    } mode_e;

    mode_e             state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [5:0]        on_h_q, on_h_d, on_m_q, on_m_d;
    logic [5:0]        off_h_q, off_h_d, off_m_q, off_m_d;
    logic              inc_h_q, inc_h_d, inc_m_q, inc_m_d;
    logic              light_q, light_d;
    logic [7:0]        bri_q, bri_d;

    // A simultaneous MODE press swallows INC.
    logic inc_press;
    assign inc_press = i_btn_inc & ~i_btn_mode;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
        return (v == last) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [10:0] to_min(input logic [5:0] h, input logic [5:0] m);
        return 11'(h) * 11'd60 + 11'(m);
    endfunction

    // Mode FSM, prescaler, idle timer and INC routing.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        idle_d  = idle_q;
        on_h_d  = on_h_q;
        on_m_d  = on_m_q;
        off_h_d = off_h_q;
        off_m_d = off_m_q;
        inc_h_d = 1'b0;
        inc_m_d = 1'b0;

        if (state_q == RUN) begin
            idle_d = '0;
            if (sec_q == SEC_LAST) begin
                sec_d   = '0;
                inc_m_d = 1'b1;
            end else begin
                sec_d = sec_q + SEC_W'(1);
            end
            if (i_btn_mode) begin
                state_d = SET_CLK_H;
            end
        end else begin
            // Held at zero so that returning to RUN starts a full minute.
            sec_d = '0;
            if (i_btn_mode || i_btn_inc) begin
                idle_d = '0;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end

            if (i_btn_mode) begin
                state_d = (state_q == SET_OFF_M) ? RUN : mode_e'(state_q + 3'd1);
            end else if (idle_q == IDLE_LAST) begin
                state_d = RUN;
                idle_d  = '0;
            end

            if (inc_press) begin
                case (state_q)
                    SET_CLK_H: inc_h_d = 1'b1;
                    SET_CLK_M: inc_m_d = 1'b1;   // RTC handles its own 59->0 hour carry
                    SET_ON_H:  on_h_d  = wrap_inc(on_h_q, 6'd23);
                    SET_ON_M:  on_m_d  = wrap_inc(on_m_q, 6'd59);
                    SET_OFF_H: off_h_d = wrap_inc(off_h_q, 6'd23);
                    SET_OFF_M: off_m_d = wrap_inc(off_m_q, 6'd59);
                    default:   ;
                endcase
            end
        end
    end

    // ON window, including the case where it spans midnight.
    logic [10:0] now_min, on_min, off_min;
    assign now_min = to_min(i_hours, i_minutes);
    assign on_min  = to_min(on_h_q, on_m_q);
    assign off_min = to_min(off_h_q, off_m_q);

    always_comb begin
        light_d = 1'b0;
        if (on_min < off_min) begin
            light_d = (now_min >= on_min) && (now_min < off_min);
        end else if (on_min > off_min) begin
            light_d = (now_min >= on_min) || (now_min < off_min);
        end
    end

    // Saturating ramp; bit 8 flags overflow on the way up and borrow on the way down.
    logic [8:0] bri_up, bri_dn;
    assign bri_up = {1'b0, bri_q} + 9'(RAMP_STEP);
    assign bri_dn = {1'b0, bri_q} - 9'(RAMP_STEP);
    always_comb begin
        if (light_q) begin
            bri_d = bri_up[8] ? 8'hFF : bri_up[7:0];
        end else begin
            bri_d = bri_dn[8] ? 8'h00 : bri_dn[7:0];
        end
    end

    always_ff @(posedge i_clk_1hz or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RUN;
            sec_q   <= '0;
            idle_q  <= '0;
            on_h_q  <= 6'(DEF_ON_H);
            on_m_q  <= 6'(DEF_ON_M);
            off_h_q <= 6'(DEF_OFF_H);
            off_m_q <= 6'(DEF_OFF_M);
            inc_h_q <= 1'b0;
            inc_m_q <= 1'b0;
            light_q <= 1'b0;
            bri_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            idle_q  <= idle_d;
            on_h_q  <= on_h_d;
            on_m_q  <= on_m_d;
            off_h_q <= off_h_d;
            off_m_q <= off_m_d;
            inc_h_q <= inc_h_d;
            inc_m_q <= inc_m_d;
            light_q <= light_d;
            bri_q   <= bri_d;
        end
    end

    // Display follows the value being edited; RUN and clock-set show the RTC.
    always_comb begin
        o_disp_h = i_hours;
        o_disp_m = i_minutes;
        case (state_q)
            SET_ON_H, SET_ON_M: begin
                o_disp_h = on_h_q;
                o_disp_m = on_m_q;
            end
            SET_OFF_H, SET_OFF_M: begin
                o_disp_h = off_h_q;
                o_disp_m = off_m_q;
            end
            default: ;
        endcase
    end

    assign o_mode        = state_q;
    assign o_inc_hours   = inc_h_q;
    assign o_inc_minutes = inc_m_q;
    assign o_light_on    = light_q;
    assign o_brightness  = bri_q;

endmodule

// File: tb/tb_light_scheduler.sv
module tb_light_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] hours = 6'd19;
    logic [5:0] minutes = 6'd0;
    logic       inc_h, inc_m, light_on;
    logic [2:0] mode;
    logic [5:0] disp_h, disp_m;
    logic [7:0] bri;

    int tests = 0;
    int fails = 0;
    logic [1:0] pulse_q[$];

    light_scheduler #(
        .SEC_PER_MIN (4),
        .RAMP_STEP   (8),
        .IDLE_TIMEOUT(30),
        .DEF_ON_H    (18),
        .DEF_ON_M    (0),
        .DEF_OFF_H   (23),
        .DEF_OFF_M   (0)
    ) dut (
        .i_clk_1hz    (clk),
        .i_rst        (rst),
        .i_btn_mode   (btn_mode),
        .i_btn_inc    (btn_inc),
        .i_hours      (hours),
        .i_minutes    (minutes),
        .o_inc_hours  (inc_h),
        .o_inc_minutes(inc_m),
        .o_mode       (mode),
        .o_disp_h     (disp_h),
        .o_disp_m     (disp_m),
        .o_light_on   (light_on),
        .o_brightness (bri)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given buttons; returns at posedge+1 with buttons released.
    task automatic cyc(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic presses(input logic m, input logic i, input int n);
        repeat (n) cyc(m, i);
    endtask

    // Expected {o_inc_hours,o_inc_minutes} queued with the stimulus, checked after the edge.
    task automatic sb_cyc(input string tag, input logic m, input logic i, input logic [1:0] exp);
        logic [1:0] e;
        pulse_q.push_back(exp);
        cyc(m, i);
        e = pulse_q.pop_front();
        chk(tag, 32'({inc_h, inc_m}), 32'(e));
    endtask

    task automatic set_time(input logic [5:0] h, input logic [5:0] mm);
        hours   = h;
        minutes = mm;
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        int e;
        logic [1:0] pe;

        // Reset state.
        @(posedge clk);
        #1;
        chk("rst_mode", 32'(mode), 0);
        chk("rst_inc_h", 32'(inc_h), 0);
        chk("rst_inc_m", 32'(inc_m), 0);
        chk("rst_light", 32'(light_on), 0);
        chk("rst_bri", 32'(bri), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Minute prescaler in RUN; INC is ignored there.
        for (int k = 1; k <= 12; k++) begin
            pe = ((k % 4) == 0) ? 2'b01 : 2'b00;
            sb_cyc("presc", 1'b0, logic'(k == 2), pe);
        end

        // INC routing to RTC.
        sb_cyc("route_mode", 1'b1, 1'b0, 2'b00);
        chk("mode_clk_h", 32'(mode), 1);
        repeat (3) sb_cyc("route_inc_h", 1'b0, 1'b1, 2'b10);
        sb_cyc("route_idle", 1'b0, 1'b0, 2'b00);
        sb_cyc("route_mode2", 1'b1, 1'b0, 2'b00);
        sb_cyc("route_inc_m", 1'b0, 1'b1, 2'b01);
        repeat (5) sb_cyc("route_wrap", 1'b1, 1'b0, 2'b00);
        chk("mode_back_run", 32'(mode), 0);
        repeat (3) sb_cyc("resume_wait", 1'b0, 1'b0, 2'b00);
        sb_cyc("resume_pulse", 1'b0, 1'b0, 2'b01);
        sb_cyc("resume_after", 1'b0, 1'b0, 2'b00);

        // MODE and INC together in SET_ON_H: mode wins.
        presses(1'b1, 1'b0, 3);
        chk("mode_on_h", 32'(mode), 3);
        chk("on_h_def", 32'(disp_h), 18);
        cyc(1'b1, 1'b1);
        chk("both_mode", 32'(mode), 4);
        chk("both_on_h", 32'(disp_h), 18);
        chk("both_on_m", 32'(disp_m), 0);

        // Reset in SET_ON_M with an INC pending.
        cyc(1'b0, 1'b1);
        chk("on_m_inc", 32'(disp_m), 1);
        chk("light_pre_rst", 32'(light_on), 1);
        btn_inc = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_mode", 32'(mode), 0);
        chk("mid_rst_inc_h", 32'(inc_h), 0);
        chk("mid_rst_inc_m", 32'(inc_m), 0);
        chk("mid_rst_light", 32'(light_on), 0);
        chk("mid_rst_bri", 32'(bri), 0);
        @(posedge clk);
        #1;
        btn_inc = 1'b0;
        rst = 1'b0;
        presses(1'b1, 1'b0, 3);
        chk("rst_on_h", 32'(disp_h), 18);
        chk("rst_on_m", 32'(disp_m), 0);
        cyc(1'b1, 1'b0);
        chk("rst_on_m2", 32'(disp_m), 0);
        cyc(1'b1, 1'b0);
        chk("rst_off_h", 32'(disp_h), 23);
        chk("rst_off_m", 32'(disp_m), 0);
        presses(1'b1, 1'b0, 2);
        chk("mode_run2", 32'(mode), 0);

        // Reset cancels a live o_inc_hours pulse.
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        chk("inc_h_live", 32'(inc_h), 1);
        #2 rst = 1'b1;
        #1;
        chk("inc_h_cancel", 32'(inc_h), 0);
        chk("inc_cancel_mode", 32'(mode), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Window ON=22:00 OFF=02:00 across midnight.
        presses(1'b1, 1'b0, 3);
        presses(1'b0, 1'b1, 4);
        presses(1'b1, 1'b0, 2);
        presses(1'b0, 1'b1, 3);
        chk("off_h_wrap", 32'(disp_h), 2);
        presses(1'b1, 1'b0, 2);
        chk("mode_run3", 32'(mode), 0);
        set_time(6'd23, 6'd30); chk("win_2330", 32'(light_on), 1);
        set_time(6'd1,  6'd59); chk("win_0159", 32'(light_on), 1);
        set_time(6'd2,  6'd0);  chk("win_0200", 32'(light_on), 0);
        set_time(6'd21, 6'd59); chk("win_2159", 32'(light_on), 0);
        set_time(6'd22, 6'd0);  chk("win_2200", 32'(light_on), 1);
        set_time(6'd12, 6'd0);  chk("win_1200", 32'(light_on), 0);

        // Brightness ramp up and down with saturation.
        presses(1'b0, 1'b0, 40);
        chk("bri_floor", 32'(bri), 0);
        set_time(6'd23, 6'd0);
        chk("ramp_light_on", 32'(light_on), 1);
        chk("ramp_start", 32'(bri), 0);
        e = 0;
        for (int i = 0; i < 34; i++) begin
            cyc(1'b0, 1'b0);
            e = (e + 8 > 255) ? 255 : e + 8;
            chk("ramp_up", 32'(bri), e);
        end
        set_time(6'd12, 6'd0);
        chk("ramp_light_off", 32'(light_on), 0);
        chk("ramp_top_hold", 32'(bri), 255);
        e = 255;
        for (int i = 0; i < 34; i++) begin
            cyc(1'b0, 1'b0);
            e = (e < 8) ? 0 : e - 8;
            chk("ramp_down", 32'(bri), e);
        end

        // Empty window: ON=OFF=10:00.
        presses(1'b1, 1'b0, 3);
        presses(1'b0, 1'b1, 12);
        chk("on_h_10", 32'(disp_h), 10);
        presses(1'b1, 1'b0, 2);
        presses(1'b0, 1'b1, 8);
        chk("off_h_10", 32'(disp_h), 10);
        presses(1'b1, 1'b0, 2);
        set_time(6'd10, 6'd0);  chk("eq_1000", 32'(light_on), 0);
        set_time(6'd9,  6'd59); chk("eq_0959", 32'(light_on), 0);
        set_time(6'd23, 6'd30); chk("eq_2330", 32'(light_on), 0);
        set_time(6'd0,  6'd0);  chk("eq_0000", 32'(light_on), 0);

        // Idle timeout from SET_OFF_M.
        presses(1'b1, 1'b0, 6);
        chk("mode_off_m", 32'(mode), 6);
        chk("off_m_disp", 32'(disp_m), 0);
        presses(1'b0, 1'b0, 29);
        chk("idle_29", 32'(mode), 6);
        cyc(1'b0, 1'b0);
        chk("idle_30", 32'(mode), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
